hicore_lsu_ctrl: RTL
====================

Name: hicore_lsu_ctrl

Overview:
- Consumer end of the issue-to-memory queue.
- Pops one memory-op entry at a time, honouring the entry's cancel bit and pipeline flush.
- Converts each entry into a single-beat valid/ready command on the data bus, then waits for the response.
- Formats load data (lane select, sign/zero extension) and hands the result to writeback with its own valid/ready handshake.

Parameters:
- AW, 32, bus/entry address width.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- q_valid  in  1  queue entry available
- q_ready  out  1  entry popped this cycle
- q_cancel  in  1  entry cancelled, drop it
- q_addr  in  AW  effective address
- q_wdata  in  32  store data, right-aligned
- q_store  in  1  1=store, 0=load
- q_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- q_unsigned  in  1  zero-extend load
- q_rd  in  RW  load destination register
- flush  in  1  kill in-flight op
- cmd_valid  out  1  bus command valid
- cmd_ready  in  1  bus accepts command
- cmd_read  out  1  1=read
- cmd_addr  out  AW  address
- cmd_wdata  out  32  lane-replicated store data
- cmd_wmask  out  4  byte enables (all 0 for reads)
- rsp_valid  in  1  bus response valid
- rsp_ready  out  1  response accepted
- rsp_rdata  in  32  read data
- rsp_err  in  1  bus error
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accepted
- wb_rd  out  RW  destination (0 for stores)
- wb_data  out  32  formatted load data
- wb_err  out  1  access fault/misalign

Behaviour:
- FSM states: IDLE, CMD, RSP, WB. Reset: state=IDLE, kill=0, all valid/ready outputs 0, data outputs 0.
- q_ready = (state==IDLE). Pop = q_valid & q_ready.
- IDLE, pop, and (q_cancel | flush): entry dropped, stay IDLE, no bus traffic.
- IDLE, pop, misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): go to WB with wb_err=1, wb_data=0, no bus command. wb_rd=q_rd for loads, 0 for stores.
- IDLE, pop, otherwise: latch fields, go to CMD.
- CMD: cmd_valid=1. All cmd fields held stable until cmd_valid & cmd_ready. On that handshake go to RSP.
- cmd_wmask: byte 4'b0001, half 4'b0011, word 4'b1111, shifted left by addr[1:0].
- cmd_wdata: byte replicated ×4, half ×2, word as-is.
- RSP: rsp_ready=1. A response is accepted only in this state, earliest the cycle after the command handshake.
  - Store, no error: go to IDLE.
  - Load, or error: go to WB.
  - kill=1: go to IDLE, result discarded.
- Load formatting: select byte/half at addr[1:0] of rsp_rdata. Sign-extend unless q_unsigned.
- WB: wb_valid=1, outputs held until wb_ready, then go to IDLE.
- Flush:
  - In CMD or RSP: sets kill. The command still completes (no valid retraction) and the response is consumed and dropped.
  - In WB: wb_valid deasserts next cycle, state goes to IDLE.
  - kill clears on entry to IDLE.
- Minimum load latency, zero-wait bus: pop at T, cmd at T+1, rsp at T+2, wb_valid at T+3. Throughput is one op per round trip; no overlap.

Optional Feature:
- HICORE_LSU_BUS_ERR_EN defined: rsp_err=1 routes to WB with wb_err=1, wb_data=0. This applies to stores too.
- Undefined: rsp_err is ignored; wb_err is set only by misalignment.

Test Plan:
- Signed load byte, addr 0x1003, rsp_rdata 0x80AABBCC: cmd_wmask=0, cmd_read=1, wb_data=0xFFFFFF80, wb_valid at T+3.
- Store half, addr 0x2002, q_wdata 0x00001234: cmd_wdata=0x12341234, cmd_wmask=4'b1100. Response consumed, no wb_valid.
- q_cancel=1 entry: popped in 1 cycle, cmd_valid stays 0. Next entry popped the following cycle.
- cmd_ready low for 3 cycles: cmd_valid/addr/wdata/wmask stable for all 4 cycles, RSP entered after the handshake.
- flush while in RSP (load): response accepted, no wb_valid, q_ready=1 the cycle after the response.
- Word load at 0x1001: no cmd_valid, wb_valid with wb_err=1, wb_data=0. With macro defined, a load with rsp_err=1 gives wb_err=1.

Source files
------------

// File: rtl/hicore_lsu_ctrl_if.sv
// Bundle for the LSU consumer end. It carries the issue-queue pop, the
// single-beat data-bus command/response and the writeback handshake.
// master: the LSU controller. slave: the queue, bus and writeback side.
interface hicore_lsu_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned RW = 5
);
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  // Issue-queue entry
  logic          q_valid;
  logic          q_ready;
  logic          q_cancel;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_wdata;
  logic          q_store;
  logic [1:0]    q_size;
  logic          q_unsigned;
  logic [RW-1:0] q_rd;

  // Data-bus command
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [BW-1:0] cmd_wmask;

  // Data-bus response
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // Writeback
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_err;

  modport master (
    input  q_valid, q_cancel, q_addr, q_wdata, q_store, q_size, q_unsigned, q_rd,
    output q_ready,
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    output wb_valid, wb_rd, wb_data, wb_err,
    input  wb_ready
  );

  modport slave (
    output q_valid, q_cancel, q_addr, q_wdata, q_store, q_size, q_unsigned, q_rd,
    input  q_ready,
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    input  wb_valid, wb_rd, wb_data, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/hicore_lsu_ctrl.sv
// hicore_lsu_ctrl: consumer end of the issue-to-memory queue.
// It pops one memory op at a time and issues a single-beat bus command.
// It then waits for the response and hands formatted load data to writeback.
// There is no overlap between ops. One op completes per bus round trip.
// Optional feature: define HICORE_LSU_BUS_ERR_EN to turn rsp_err into a
// writeback fault (wb_err=1, wb_data=0). This applies to loads and stores.
// When the macro is undefined, rsp_err is ignored.
module hicore_lsu_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned RW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  hicore_lsu_ctrl_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2,
    WB   = 2'd3
  } state_t;

  // Fields of the popped entry that are needed after the command is issued
  typedef struct packed {
    logic [1:0]    lane;
    logic          store;
    logic [1:0]    size;
    logic          uns;
    logic [RW-1:0] rd;
  } op_t;

  state_t        state_q;
  state_t        state_d;
  logic          kill_q;
  logic          kill_d;
  op_t           op_q;

  logic          pop_c;
  logic          drop_c;
  logic          misal_c;
  logic          bus_err_c;
  logic          accept_c;
  logic          rsp_to_wb_c;
  logic [BW-1:0] base_mask_c;
  logic [BW-1:0] st_mask_c;
  logic [DW-1:0] st_data_c;
  logic [DW-1:0] lane_c;
  logic [DW-1:0] ld_data_c;

`ifdef HICORE_LSU_BUS_ERR_EN
  assign bus_err_c = bus.rsp_err;
`else
  logic unused_rsp_err;
  assign unused_rsp_err = bus.rsp_err;
  assign bus_err_c      = 1'b0;
`endif

  // Pop qualification and alignment check on the queue head
  always_comb begin
    pop_c  = bus.q_valid & bus.q_ready;
    drop_c = bus.q_cancel | flush;
    case (bus.q_size)
      2'd0:    misal_c = 1'b0;
      2'd1:    misal_c = bus.q_addr[0];
      2'd2:    misal_c = |bus.q_addr[1:0];
      default: misal_c = 1'b1;
    endcase
  end

  // Store byte enables and lane replication
  always_comb begin
    case (bus.q_size)
      2'd0:    base_mask_c = 4'b0001;
      2'd1:    base_mask_c = 4'b0011;
      default: base_mask_c = 4'b1111;
    endcase
    st_mask_c = BW'(base_mask_c << bus.q_addr[1:0]);
    case (bus.q_size)
      2'd0:    st_data_c = {4{bus.q_wdata[7:0]}};
      2'd1:    st_data_c = {2{bus.q_wdata[15:0]}};
      default: st_data_c = bus.q_wdata;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    lane_c = bus.rsp_rdata >> {op_q.lane, 3'b000};
    case (op_q.size)
      2'd0:    ld_data_c = op_q.uns ? {24'd0, lane_c[7:0]}
                                    : {{24{lane_c[7]}}, lane_c[7:0]};
      2'd1:    ld_data_c = op_q.uns ? {16'd0, lane_c[15:0]}
                                    : {{16{lane_c[15]}}, lane_c[15:0]};
      default: ld_data_c = lane_c;
    endcase
  end

  // Next-state and kill tracking
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        if (pop_c && !drop_c) begin
          state_d = misal_c ? WB : CMD;
        end
      end
      CMD: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (bus.cmd_ready) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (bus.rsp_valid) begin
          if (kill_q || flush) begin
            state_d = IDLE;
          end else if (bus_err_c || !op_q.store) begin
            state_d = WB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WB: begin
        if (flush || bus.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      kill_d = 1'b0;
    end
  end

  // Transition decodes used by the datapath registers
  always_comb begin
    accept_c    = (state_q == IDLE) && (state_d != IDLE);
    rsp_to_wb_c = (state_q == RSP) && (state_d == WB);
  end

  // State and kill registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Handshake outputs track the next state so they stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.q_ready   <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.rsp_ready <= 1'b0;
      bus.wb_valid  <= 1'b0;
    end else begin
      bus.q_ready   <= (state_d == IDLE);
      bus.cmd_valid <= (state_d == CMD);
      bus.rsp_ready <= (state_d == RSP);
      bus.wb_valid  <= (state_d == WB);
    end
  end

  // Latch the accepted op and its bus command, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      bus.cmd_read  <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_wdata <= '0;
      bus.cmd_wmask <= '0;
    end else if (accept_c) begin
      op_q.lane     <= bus.q_addr[1:0];
      op_q.store    <= bus.q_store;
      op_q.size     <= bus.q_size;
      op_q.uns      <= bus.q_unsigned;
      op_q.rd       <= bus.q_rd;
      if (!misal_c) begin
        bus.cmd_read  <= ~bus.q_store;
        bus.cmd_addr  <= bus.q_addr;
        bus.cmd_wdata <= st_data_c;
        bus.cmd_wmask <= bus.q_store ? st_mask_c : '0;
      end
    end
  end

  // Writeback payload: an alignment fault at pop, or a bus result from RSP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
      bus.wb_err  <= 1'b0;
    end else if (accept_c && misal_c) begin
      bus.wb_rd   <= bus.q_store ? '0 : bus.q_rd;
      bus.wb_data <= '0;
      bus.wb_err  <= 1'b1;
    end else if (rsp_to_wb_c) begin
      bus.wb_rd   <= op_q.store ? '0 : op_q.rd;
      bus.wb_data <= bus_err_c ? '0 : ld_data_c;
      bus.wb_err  <= bus_err_c;
    end
  end

endmodule
